// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with one-hot, thermometer and auto-scan modes.
// Address loads through a valid/ready port; scan mode steps the address every DWELL cycles.
module decoder_scan_n #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        a,
  input  logic                a_valid,
  output logic                a_ready,
  output logic [(1<<N)-1:0]   out,
  output logic [N-1:0]        cur_addr,
  output logic                scan_wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
  localparam logic [N-1:0]  AddrMax   = '1;

  logic [N-1:0]  addr_q, addr_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          wrap_q, wrap_d;
  logic          in_scan_q, in_scan_d;
  logic          scan, thermo;

  assign scan    = (mode == 2'b10);
  assign thermo  = (mode == 2'b01);
  assign a_ready = en & ~rst & ~scan;

  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    in_scan_d = in_scan_q;
    out_d     = '0;
    wrap_d    = 1'b0;
    if (en) begin
      in_scan_d = scan;
      if (scan) begin
        // First edge in scan mode restarts the dwell so the current address gets a full dwell
        if (!in_scan_q) begin
          cnt_d = '0;
        end else if (cnt_q == DwellLast) begin
          cnt_d  = '0;
          addr_d = addr_q + 1'b1;
          wrap_d = (addr_q == AddrMax);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
        if (a_valid) addr_d = a;
      end
      for (int unsigned i = 0; i < W; i++) begin
        out_d[i] = thermo ? (addr_d >= N'(i)) : (addr_d == N'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      wrap_q    <= 1'b0;
      in_scan_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      wrap_q    <= wrap_d;
      in_scan_q <= in_scan_d;
    end
  end

  assign out       = out_q;
  assign cur_addr  = addr_q;
  assign scan_wrap = wrap_q;

endmodule
